// File: rtl/mux_4to1_rr_sel_if.sv
// ----------------------------------------------------------------------------
// mux_4to1_rr_sel_if
// Bundles the request/handshake/select signals between the round-robin
// select generator and its surroundings.
//   req    [3:0]  per-source request (bit 0 = a ... bit 3 = d)
//   ready         downstream accepts the current mux output
//   sel    [1:0]  mux select code driven by the arbiter
//   grant  [3:0]  one-hot owning source, 0 when idle
//   valid         mux output is valid this cycle
//   last          current beat is the final beat of the grant
// Modports:
//   master - the arbiter (drives sel/grant/valid/last)
//   slave  - the sources and consumer (drive req/ready)
// ----------------------------------------------------------------------------
interface mux_4to1_rr_sel_if;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       last;

    modport master (
        input  req,
        input  ready,
        output sel,
        output grant,
        output valid,
        output last
    );

    modport slave (
        output req,
        output ready,
        input  sel,
        input  grant,
        input  valid,
        input  last
    );
endinterface

// File: rtl/mux_4to1_rr_sel.sv
// ----------------------------------------------------------------------------
// mux_4to1_rr_sel
// Round-robin select generator for a 4:1 output mux. Picks one of four
// requesting sources, drives the mux select code and a one-hot grant, and
// hands the selected data downstream with a valid/ready handshake. A granted
// source may move up to BURST beats before the pointer rotates.
// Parameters:
//   BURST  maximum beats per grant, 1..15
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   bus    mux_4to1_rr_sel_if.master (req, ready in; sel, grant, valid, last out)
// ----------------------------------------------------------------------------
module mux_4to1_rr_sel #(
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_4to1_rr_sel_if.master     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

    state_t     state, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ptr;
    logic [1:0] pick;
    logic       valid;

    // Search starts one past the most recently selected source, so the
    // source just served gets lowest priority next time.
    assign ptr = sel_q + 2'd1;

    // Walk the offsets from farthest to nearest so the nearest set request
    // (in wrap order from ptr) is the one left in pick.
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[ptr + 2'(i)]) begin
                pick = ptr + 2'(i);
            end
        end
    end

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state;
        sel_d   = sel_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        valid   = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    sel_d   = pick;
                    grant_d = 4'b0001 << pick;
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // valid follows the owner's request combinationally.
                valid = bus.req[sel_q];
                if (!bus.req[sel_q]) begin
                    // Owner withdrew before its beat moved: end the grant.
                    grant_d = 4'b0000;
                    state_d = IDLE;
                end else if (bus.ready) begin
                    if (cnt_q == LAST_CNT) begin
                        grant_d = 4'b0000;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                // valid && !ready: everything holds (defaults).
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= 2'b11;   // first search after reset starts at source a
            grant_q <= 4'b0000;
            cnt_q   <= 4'd0;
        end else begin
            state   <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.valid = valid;
    assign bus.last  = valid && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_mux_4to1_rr_sel.sv
// ----------------------------------------------------------------------------
// tb_mux_4to1_rr_sel
// Self-checking bench for mux_4to1_rr_sel (BURST = 4). A behavioural model
// tracks owner / beats served / last-served source and predicts outputs each
// cycle; a hand-written vector table and a few corner-case sequences add
// explicit expectations on top.
// ----------------------------------------------------------------------------
module tb_mux_4to1_rr_sel;

    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_4to1_rr_sel_if bus ();

    mux_4to1_rr_sel #(.BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Sampled DUT outputs of the most recent step.
    logic [1:0] s_sel;
    logic [3:0] s_grant;
    logic       s_valid;
    logic       s_last;

    // Behavioural model: which source owns the mux (-1 = none), how many
    // beats it has moved, and which source was served most recently.
    int m_owner  = -1;
    int m_beats  = 0;
    int m_served = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic [3:0] q, input logic rd);
        if (r) begin
            m_owner  = -1;
            m_beats  = 0;
            m_served = 3;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int s;
                s = (m_served + k) % 4;
                if (q[s]) begin
                    m_owner  = s;
                    m_served = s;
                    m_beats  = 0;
                    break;
                end
            end
        end else if (!q[m_owner]) begin
            m_owner = -1;
        end else if (rd) begin
            m_beats++;
            if (m_beats == BURST) m_owner = -1;
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample and
    // compare on the falling edge, then advance the model.
    task automatic step(input logic r, input logic [3:0] q, input logic rd, input bit chk);
        logic [1:0] e_sel;
        logic [3:0] e_grant;
        logic       e_valid;
        logic       e_last;
        rst       = r;
        bus.req   = q;
        bus.ready = rd;
        @(negedge clk);
        s_sel   = bus.sel;
        s_grant = bus.grant;
        s_valid = bus.valid;
        s_last  = bus.last;
        if (chk) begin
            e_sel   = 2'(m_served);
            e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            e_valid = (m_owner >= 0) && q[m_owner];
            e_last  = e_valid && (m_beats == BURST - 1);
            check("model.sel",   32'(s_sel),   32'(e_sel));
            check("model.grant", 32'(s_grant), 32'(e_grant));
            check("model.valid", 32'(s_valid), 32'(e_valid));
            check("model.last",  32'(s_last),  32'(e_last));
        end
        model_update(r, q, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0000, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ready;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic       last;
    } vec_t;

    vec_t tbl[15];
    logic [1:0] grant_seq[$];
    logic [3:0] prev_grant;

    initial begin
        bus.req   = 4'b0000;
        bus.ready = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- table-driven vectors ----------------
        //          rst   req     rdy   sel    grant   v     l
        tbl[0]  = '{1'b1, 4'hf, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0}; // 2nd reset cycle
        tbl[1]  = '{1'b0, 4'hf, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0}; // idle, picks a
        tbl[2]  = '{1'b0, 4'hf, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0}; // beat 1 stalled
        tbl[3]  = '{1'b0, 4'hf, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0}; // beat 1 moves
        tbl[4]  = '{1'b1, 4'hf, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0}; // reset mid-burst
        tbl[5]  = '{1'b1, 4'h2, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'h2, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0}; // idle, picks b
        tbl[7]  = '{1'b0, 4'h2, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0}; // beat 1
        tbl[8]  = '{1'b0, 4'h2, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0}; // beat 2
        tbl[9]  = '{1'b0, 4'h2, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0}; // beat 3
        tbl[10] = '{1'b0, 4'h2, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1}; // beat 4, last
        tbl[11] = '{1'b0, 4'h2, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0}; // bubble, re-pick b
        tbl[12] = '{1'b0, 4'h2, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0}; // beat 1 again
        tbl[13] = '{1'b0, 4'h0, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0}; // req drops
        tbl[14] = '{1'b0, 4'h0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0}; // idle, sel kept

        step(1'b1, 4'hf, 1'b1, 1'b0); // first reset cycle: outputs unknown before it
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].ready, 1'b1);
            check($sformatf("tbl%0d.sel", i),   32'(s_sel),   32'(tbl[i].sel));
            check($sformatf("tbl%0d.grant", i), 32'(s_grant), 32'(tbl[i].grant));
            check($sformatf("tbl%0d.valid", i), 32'(s_valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d.last", i),  32'(s_last),  32'(tbl[i].last));
        end

        // ---------------- full contention: a, b, c, d, a ----------------
        do_reset();
        prev_grant = 4'b0000;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 4'hf, 1'b1, 1'b1);
            if (s_grant != 4'b0000 && prev_grant == 4'b0000) grant_seq.push_back(s_sel);
            prev_grant = s_grant;
        end
        check("contention.count", 32'(grant_seq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] got;
            got = (i < grant_seq.size()) ? grant_seq[i] : 2'bxx;
            check($sformatf("contention.sel%0d", i), 32'(got), 32'(i % 4));
        end

        // ---------------- backpressure after beat 2 ----------------
        do_reset();
        step(1'b0, 4'b0001, 1'b1, 1'b1);          // idle, picks a
        step(1'b0, 4'b0001, 1'b1, 1'b1);          // beat 1
        step(1'b0, 4'b0001, 1'b1, 1'b1);          // beat 2
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0001, 1'b0, 1'b1);
            check("bp.sel",   32'(s_sel),   32'd0);
            check("bp.grant", 32'(s_grant), 32'b0001);
            check("bp.valid", 32'(s_valid), 32'd1);
            check("bp.last",  32'(s_last),  32'd0);
        end
        step(1'b0, 4'b0001, 1'b1, 1'b1);          // beat 3
        check("bp.beat3_last", 32'(s_last), 32'd0);
        step(1'b0, 4'b0001, 1'b1, 1'b1);          // beat 4
        check("bp.beat4_last", 32'(s_last), 32'd1);
        step(1'b0, 4'b0001, 1'b1, 1'b1);          // bubble
        check("bp.bubble_grant", 32'(s_grant), 32'd0);

        // ---------------- early drop of source c ----------------
        do_reset();
        step(1'b0, 4'b0100, 1'b1, 1'b1);          // idle, picks c
        step(1'b0, 4'b1100, 1'b1, 1'b1);          // beat 1
        step(1'b0, 4'b1100, 1'b1, 1'b1);          // beat 2
        check("drop.grant_c", 32'(s_grant), 32'b0100);
        step(1'b0, 4'b1000, 1'b1, 1'b1);          // c drops: no transfer
        check("drop.valid", 32'(s_valid), 32'd0);
        step(1'b0, 4'b1000, 1'b1, 1'b1);          // idle
        check("drop.idle_grant", 32'(s_grant), 32'd0);
        check("drop.idle_sel",   32'(s_sel),   32'd2);
        step(1'b0, 4'b1000, 1'b1, 1'b1);
        check("drop.sel_d",   32'(s_sel),   32'd3);
        check("drop.grant_d", 32'(s_grant), 32'b1000);

        // ---------------- mid-burst reset ----------------
        do_reset();
        step(1'b0, 4'hf, 1'b1, 1'b1);             // idle, picks a
        step(1'b0, 4'hf, 1'b1, 1'b1);             // beat 1
        step(1'b1, 4'hf, 1'b1, 1'b1);             // beat 2 with reset
        step(1'b0, 4'hf, 1'b1, 1'b1);
        check("rst.sel",   32'(s_sel),   32'd3);
        check("rst.grant", 32'(s_grant), 32'd0);
        check("rst.valid", 32'(s_valid), 32'd0);
        check("rst.last",  32'(s_last),  32'd0);
        step(1'b0, 4'hf, 1'b1, 1'b1);
        check("rst.next_sel",   32'(s_sel),   32'd0);
        check("rst.next_grant", 32'(s_grant), 32'b0001);

        // ---------------- randomized against the model ----------------
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [3:0] q;
            logic       rd;
            r  = ($urandom_range(0, 59) == 0);
            q  = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3))
                                             : 4'($urandom);
            rd = ($urandom_range(0, 3) != 0);
            step(r, q, rd, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
